// File: rtl/disp_seq_pkg.sv
// Shared types and helpers for the display mode sequencer.
// Mode stepping wraps inside [mode_min, mode_max] in either direction.
package disp_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } disp_seq_state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    function automatic int unsigned next_mode(
        input int unsigned cur,
        input logic        dir,
        input int unsigned mode_min,
        input int unsigned mode_max
    );
        if (dir == DIR_DN)
            return (cur <= mode_min) ? mode_max : cur - 1;
        return (cur >= mode_max) ? mode_min : cur + 1;
    endfunction

endpackage

// File: rtl/display_mode_sequencer_btn_debounce.sv
// Level debouncer: output follows input only after the input has
// differed from it for CYCLES consecutive clocks.
module btn_debounce #(
    parameter int unsigned CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 1'b0;
            cnt  <= '0;
        end else if (din == dout) begin
            cnt  <= '0;
        end else if (cnt == C_LAST) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_mode_sequencer.sv
// TPG mode sequencer: lock/settle gating, dwell auto-advance, button step.
// Define DISP_SEQ_DEBOUNCE_EN to insert btn_debounce on the step input.
module display_mode_sequencer
    import disp_seq_pkg::*;
#(
    parameter int unsigned MODE_W        = 4,
    parameter int unsigned MODE_MIN      = 1,
    parameter int unsigned MODE_MAX      = 11,
    parameter int unsigned DWELL_CYCLES  = 33554432,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned DEB_CYCLES    = 250000,
    parameter int unsigned HB_BIT        = 23
) (
    input  logic              PXLCLK_I,
    input  logic              RST_I,
    input  logic              LOCKED_I,
    input  logic              AUTO_EN_I,
    input  logic              STEP_I,
    input  logic              DIR_I,
    output logic [MODE_W-1:0] TPG_MODE_O,
    output logic              MODE_CHG_O,
    output logic              DEN_O,
    output logic              LED_O
);

    if (!(MODE_MIN < MODE_MAX && MODE_MAX < 2**MODE_W))
        $error("display_mode_sequencer: bad mode range");
    if (DWELL_CYCLES < 2 || SETTLE_CYCLES < 1 || DEB_CYCLES < 1)
        $error("display_mode_sequencer: bad cycle counts");

    localparam int unsigned DW = $clog2(DWELL_CYCLES);
    localparam int unsigned SW =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DW-1:0] DW_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [SW-1:0] SW_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [MODE_W-1:0] M_MIN = MODE_W'(MODE_MIN);

    disp_seq_state_t   state_q, state_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [HB_BIT:0]   hb_q;
    logic              chg_q;
    logic              lock_s1, lock_s2;
    logic              stp_s1, stp_s2, stp_s3;
    logic              stp_lvl;
    logic              step_evt;

`ifdef DISP_SEQ_DEBOUNCE_EN
    btn_debounce #(
        .CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk (PXLCLK_I),
        .rst (RST_I),
        .din (stp_s2),
        .dout(stp_lvl)
    );
`else
    assign stp_lvl = stp_s2;
`endif

    assign step_evt = stp_lvl & ~stp_s3;

    always_ff @(posedge PXLCLK_I) begin
        if (RST_I) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
            stp_s1  <= 1'b0;
            stp_s2  <= 1'b0;
            stp_s3  <= 1'b0;
        end else begin
            lock_s1 <= LOCKED_I;
            lock_s2 <= lock_s1;
            stp_s1  <= STEP_I;
            stp_s2  <= stp_s1;
            stp_s3  <= stp_lvl;
        end
    end

    always_ff @(posedge PXLCLK_I) begin
        if (RST_I) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
            dwell_q  <= '0;
            mode_q   <= M_MIN;
            chg_q    <= 1'b0;
            hb_q     <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            dwell_q  <= dwell_d;
            mode_q   <= mode_d;
            chg_q    <= (mode_d != mode_q);
            hb_q     <= (state_d == WAIT_LOCK) ? '0 : hb_q + 1'b1;
        end
    end

    // Lock loss outranks any step or dwell advance in the same cycle
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        dwell_d  = dwell_q;
        mode_d   = mode_q;
        unique case (state_q)
            WAIT_LOCK: begin
                settle_d = '0;
                dwell_d  = '0;
                mode_d   = M_MIN;
                if (lock_s2)
                    state_d = SETTLE;
            end
            SETTLE: begin
                dwell_d = '0;
                mode_d  = M_MIN;
                if (!lock_s2) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SW_LAST) begin
                    state_d  = RUN;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            RUN: begin
                settle_d = '0;
                if (!lock_s2) begin
                    state_d = WAIT_LOCK;
                    dwell_d = '0;
                    mode_d  = M_MIN;
                end else if (step_evt) begin
                    dwell_d = '0;
                    mode_d  = MODE_W'(next_mode(32'(mode_q), DIR_I,
                                                MODE_MIN, MODE_MAX));
                end else if (dwell_q == DW_LAST) begin
                    dwell_d = '0;
                    if (AUTO_EN_I)
                        mode_d = MODE_W'(next_mode(32'(mode_q), DIR_UP,
                                                   MODE_MIN, MODE_MAX));
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    assign TPG_MODE_O = mode_q;
    assign MODE_CHG_O = chg_q;
    assign DEN_O      = (state_q == RUN);
    assign LED_O      = hb_q[HB_BIT];

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Scoreboard bench for display_mode_sequencer: expected mode changes are
// queued with their edge number and matched against MODE_CHG_O pulses.
module tb_display_mode_sequencer;

`ifdef DISP_SEQ_DEBOUNCE_EN
    localparam int L = 10;
`else
    localparam int L = 2;
`endif

    logic       clk = 1'b0;
    logic       rst, locked, auto_en, step, dir;
    logic [3:0] mode;
    logic       chg, den, led;

    typedef struct {
        int e;
        int m;
    } exp_t;

    exp_t sb[$];
    exp_t x;
    int   edge_n = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   led_hi = 0;
    int   e0, run, b, s, c0, g, k, k2;

    display_mode_sequencer #(
        .MODE_W(4), .MODE_MIN(1), .MODE_MAX(3),
        .DWELL_CYCLES(16), .SETTLE_CYCLES(4),
        .DEB_CYCLES(8), .HB_BIT(2)
    ) dut (
        .PXLCLK_I  (clk),
        .RST_I     (rst),
        .LOCKED_I  (locked),
        .AUTO_EN_I (auto_en),
        .STEP_I    (step),
        .DIR_I     (dir),
        .TPG_MODE_O(mode),
        .MODE_CHG_O(chg),
        .DEN_O     (den),
        .LED_O     (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (edge %0d)",
                     tag, got, want, edge_n);
        end
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int e, input int m);
        exp_t t;
        t.e = e;
        t.m = m;
        sb.push_back(t);
    endtask

    always @(negedge clk) begin
        if (den === 1'b1 && led === 1'b1)
            led_hi = 1;
        if (chg === 1'b1) begin
            check("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("chg_mode", int'(mode), x.m);
                check("chg_edge", edge_n, x.e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; locked = 1'b0; auto_en = 1'b0;
        step = 1'b0; dir = 1'b0;
        wait_edge(2);
        check("rst_mode", int'(mode), 1);
        check("rst_chg", int'(chg), 0);
        check("rst_den", int'(den), 0);
        check("rst_led", int'(led), 0);
        rst = 1'b0;
        wait_edge(5);
        check("nolock_den", int'(den), 0);

        e0 = edge_n;
        locked = 1'b1;
        wait_edge(e0 + 6);
        check("den_early", int'(den), 0);
        wait_edge(e0 + 7);
        check("den_rise", int'(den), 1);
        check("run_mode", int'(mode), 1);
        run = e0 + 7;

        auto_en = 1'b1;
        push(run + 16, 2);
        push(run + 32, 3);
        push(run + 48, 1);
        wait_edge(run + 48);
        check("auto_wrap", int'(mode), 1);
        check("led_toggle", led_hi, 1);

        b = run + 48;
        wait_edge(b + 2);
        dir = 1'b1;
        step = 1'b1;
        s = b + 3;
        push(s + L, 3);
        push(s + L + 16, 1);
        wait_edge(b + 14);
        step = 1'b0;
        wait_edge(s + L + 16);
        check("dn_then_auto_up", int'(mode), 1);

        c0 = s + L + 16;
        push(c0 + 16, 2);
        push(c0 + 32, 1);
        push(c0 + 48, 2);
        wait_edge(c0 + 31 - L);
        step = 1'b1;
        wait_edge(c0 + 43 - L);
        step = 1'b0;
        wait_edge(c0 + 48);
        check("collision", int'(mode), 2);

        g = c0 + 48;
        auto_en = 1'b0;
        dir = 1'b0;
`ifdef DISP_SEQ_DEBOUNCE_EN
        wait_edge(g + 1);
        step = 1'b1;
        wait_edge(g + 6);
        step = 1'b0;
        wait_edge(g + 30);
        check("glitch", int'(mode), 2);
        step = 1'b1;
        push(g + 31 + L, 3);
        wait_edge(g + 42);
        step = 1'b0;
`else
        wait_edge(g + 1);
        step = 1'b1;
        push(g + 2 + L, 3);
        wait_edge(g + 2);
        step = 1'b0;
`endif
        wait_edge(g + 60);
        check("up_step", int'(mode), 3);

        k = g + 60;
        locked = 1'b0;
        wait_edge(k + 2);
        check("lost_den_k2", int'(den), 1);
        push(k + 3, 1);
        wait_edge(k + 3);
        check("lost_mode", int'(mode), 1);
        check("lost_den", int'(den), 0);
        check("lost_led", int'(led), 0);
        wait_edge(k + 4);
        step = 1'b1;
        wait_edge(k + 16);
        step = 1'b0;
        wait_edge(k + 30);
        check("unlock_step", int'(mode), 1);
        check("unlock_den", int'(den), 0);

        k2 = k + 30;
        locked = 1'b1;
        wait_edge(k2 + 7);
        check("relock_den", int'(den), 1);
        wait_edge(k2 + 8);
        step = 1'b1;
        push(k2 + 9 + L, 2);
        wait_edge(k2 + 20);
        step = 1'b0;
        wait_edge(k2 + 40);
        check("relock_step", int'(mode), 2);
        rst = 1'b1;
        wait_edge(k2 + 41);
        check("midrst_mode", int'(mode), 1);
        check("midrst_chg", int'(chg), 0);
        check("midrst_den", int'(den), 0);
        check("midrst_led", int'(led), 0);
        rst = 1'b0;
        wait_edge(k2 + 60);
        check("sb_empty", int'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/display_mode_sequencer.md
# display_mode_sequencer

Single-clock sequencer for the display pipeline's test-pattern generator. It holds the output idle until the pixel PLL is locked and settled, then selects a TPG mode in a bounded range. The mode advances automatically on a dwell timer or manually from a front-panel button, in either direction, with wrap-around. It also drives the data-enable and a lock-qualified heartbeat LED, and sits between the PLL/reset logic and `hdmi_top`.

## Interface
Parameters:
- `MODE_W`, 4: width of the mode output.
- `MODE_MIN`, 1: first valid mode.
- `MODE_MAX`, 11: last valid mode. Elaboration error unless `MODE_MIN < MODE_MAX < 2**MODE_W`.
- `DWELL_CYCLES`, 33554432: cycles per auto-advance. Must be ≥ 2.
- `SETTLE_CYCLES`, 1024: cycles after lock before output is enabled. Must be ≥ 1.
- `DEB_CYCLES`, 250000: button stable time. Used only with `DISP_SEQ_DEBOUNCE_EN`.
- `HB_BIT`, 23: heartbeat counter bit driven to the LED.

Ports:
- `PXLCLK_I`, in, 1: pixel clock; the only clock.
- `RST_I`, in, 1: reset, synchronous, active-high.
- `LOCKED_I`, in, 1: PLL lock. Asynchronous; synchronised internally with 2 flops.
- `AUTO_EN_I`, in, 1: enables auto-advance. Quasi-static.
- `STEP_I`, in, 1: raw button, active-high. Asynchronous.
- `DIR_I`, in, 1: step direction; 0 = up, 1 = down. Sampled on the step event.
- `TPG_MODE_O`, out, `MODE_W`: current mode. Registered.
- `MODE_CHG_O`, out, 1: one-cycle pulse when `TPG_MODE_O` changes.
- `DEN_O`, out, 1: data enable to the TPG.
- `LED_O`, out, 1: heartbeat.

## Operation
- **FSM states.** `WAIT_LOCK`, `SETTLE`, `RUN`.
- **`WAIT_LOCK`:**
  - Outputs: `TPG_MODE_O=MODE_MIN`, `DEN_O=0`, `LED_O=0`.
  - All counters are cleared.
  - Synchronised lock = 1 moves to `SETTLE`.
- **`SETTLE`:** the settle counter counts 0..`SETTLE_CYCLES-1`. At terminal count, move to `RUN`.
- **`RUN`:**
  - `DEN_O=1`.
  - The dwell counter counts 0..`DWELL_CYCLES-1` and wraps.
  - Advance event = (dwell terminal count AND `AUTO_EN_I`) OR step event.
- **Loss of lock.** Synchronised lock = 0 in `SETTLE` or `RUN` returns to `WAIT_LOCK` on the next edge. This takes priority over any advance in the same cycle.
- **Up step:**
  - `MODE_MAX` goes to `MODE_MIN`.
  - Otherwise mode + 1.
- **Down step:**
  - `MODE_MIN` goes to `MODE_MAX`.
  - Otherwise mode − 1.
  - Auto-advance is always up.
- **Step and dwell terminal in the same cycle:** exactly one advance, in the `DIR_I` direction. The dwell counter restarts at 0.
- **Any step event** restarts the dwell counter at 0, so the full dwell follows a manual step.
- **`MODE_CHG_O`** is registered alongside `TPG_MODE_O` and is high exactly in the first cycle the new value is visible. No pulse when entering `WAIT_LOCK` from reset.
- **Heartbeat counter** is `HB_BIT+1` bits, free-running while in `SETTLE`/`RUN` and cleared otherwise. `LED_O` is bit `HB_BIT`.
- **Step events outside `RUN`** are discarded.
- **Counter widths:** `$clog2` of their terminal value; no overflow beyond the terminal count.

## Timing
- **Reset values:**
  - `TPG_MODE_O=MODE_MIN`.
  - `MODE_CHG_O=0`, `DEN_O=0`, `LED_O=0`.
  - State `WAIT_LOCK`; all counters and sync flops 0.
- **`RST_I` mid-operation:** same result on the next edge, regardless of state.
- **Lock path:** `LOCKED_I` rising at edge 0 gives state `SETTLE` after edge 3 and `DEN_O=1` after edge 3+`SETTLE_CYCLES`.
- **Step path without debounce** (`STEP_I` first sampled high at edge 1):
  - Sync flops s1/s2 at edges 1–2.
  - Event = s2 & ~s3.
  - `TPG_MODE_O` updates at edge 3.
- **Step path with debounce:** update at edge `DEB_CYCLES`+3.
- **Auto-advance:** `TPG_MODE_O` updates every `DWELL_CYCLES` edges exactly.

## Configuration
- Macro: `DISP_SEQ_DEBOUNCE_EN`.
- **Defined:**
  - s2 feeds a debouncer. Its output toggles only after s2 has differed from it for `DEB_CYCLES` consecutive cycles.
  - Any shorter glitch resets the count.
  - The edge detector acts on the debounced level.
- **Undefined:**
  - The debouncer is absent and `DEB_CYCLES` is ignored.
  - Edge detection acts on s2 directly. One event per rising edge of the synchronised input.

## Structure
- **Package `disp_seq_pkg`:**
  - State enum `disp_seq_state_t` (`WAIT_LOCK`, `SETTLE`, `RUN`).
  - Direction localparams `DIR_UP=0`, `DIR_DN=1`.
  - Function `next_mode(cur, dir, min, max)`.
- **Sub-module `btn_debounce`:**
  - Parameter `CYCLES`.
  - Ports: clock, reset, in, out.
  - Instantiated only under the macro.

## Test plan
Bench parameters: `MODE_MIN=1`, `MODE_MAX=3`, `DWELL_CYCLES=16`, `SETTLE_CYCLES=4`, `DEB_CYCLES=8`.
- **Reset/lock:** hold `RST_I` 2 cycles, raise `LOCKED_I` → `DEN_O` rises 7 edges later, mode=1, no `MODE_CHG_O`.
- **Auto wrap:** `AUTO_EN_I=1` → mode 1→2→3→1, every 16 cycles, with one `MODE_CHG_O` pulse each.
- **Down step wrap:** mode=1, `DIR_I=1`, one clean step → mode=3 at edge 3 (no macro) / edge 11 (macro). Dwell restarts, so the next auto-advance comes 16 cycles later.
- **Collision:** step with `DIR_I=1` in the dwell terminal cycle at mode=2 → single change to 1.
- **Glitch (macro):** 5-cycle `STEP_I` pulse → no change. A 12-cycle pulse → exactly one increment.
- **Lock loss mid-run:** at mode=3, drop `LOCKED_I` → within 3 edges mode=1, `DEN_O=0`, `LED_O=0`. Steps while unlocked are ignored.
